// File: rtl/tone_sequencer_if.sv
// Bus between the game logic and the tone sequencer: event triggers in, note/gate/status out.
// With TONE_SEQ_MUTE_EN defined the bus also carries a mute input.
interface tone_sequencer_if;
    // play_* are single-cycle requests with no ready: the sequencer always samples them
    // and arbitrates internally; busy/done report progress, freq/tone_en feed the generator.
    logic        play_eat;
    logic        play_over;
    logic [31:0] freq;
    logic        tone_en;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;
`ifdef TONE_SEQ_MUTE_EN
    logic        mute;

    modport slave  (input  play_eat, play_over, mute,
                    output freq, tone_en, busy, done, dbg_state);
    modport master (output play_eat, play_over, mute,
                    input  freq, tone_en, busy, done, dbg_state);
`else
    modport slave  (input  play_eat, play_over,
                    output freq, tone_en, busy, done, dbg_state);
    modport master (output play_eat, play_over,
                    input  freq, tone_en, busy, done, dbg_state);
`endif
endinterface

// File: rtl/tone_sequencer.sv
// Plays the "eat" / "over" melodies from a constant note ROM for the snake audio path.
// Optional feature macro: TONE_SEQ_MUTE_EN (adds a mute input that silences freq/tone_en).
module tone_sequencer #(
    parameter int FCLK        = 50_000_000,
    parameter int TICK_CYCLES = FCLK / 1000,
    parameter int GAP_MS      = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    tone_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    localparam logic [31:0] TICK_LAST = 32'(TICK_CYCLES - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_MS - 1);

    // ROM index 0..2 is EAT, 3..7 is OVER
    function automatic logic [31:0] note_freq(input logic [2:0] idx);
        case (idx)
            3'd0:    note_freq = 32'd1047;
            3'd1:    note_freq = 32'd1319;
            3'd2:    note_freq = 32'd1568;
            3'd3:    note_freq = 32'd784;
            3'd4:    note_freq = 32'd659;
            3'd5:    note_freq = 32'd523;
            3'd6:    note_freq = 32'd0;
            default: note_freq = 32'd392;
        endcase
    endfunction

    function automatic logic [15:0] note_dur(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1:       note_dur = 16'd60;
            3'd2:             note_dur = 16'd80;
            3'd3, 3'd4, 3'd5: note_dur = 16'd150;
            3'd6:             note_dur = 16'd50;
            default:          note_dur = 16'd300;
        endcase
    endfunction

    state_t      r_state;
    logic [2:0]  r_idx;
    logic [31:0] r_tick;
    logic [15:0] r_ms;
    logic [31:0] r_freq;
    logic        r_tone_en;
    logic        r_busy;
    logic        r_done;

    logic        w_mute;
    logic        w_over_active;
    logic        w_start_over;
    logic        w_start_eat;
    logic [2:0]  w_start_idx;
    logic [31:0] w_start_freq;
    logic [2:0]  w_next_idx;
    logic [31:0] w_next_freq;
    logic [31:0] w_cur_freq;
    logic [15:0] w_cur_dur;
    logic        w_last;
    logic        w_tick_wrap;
    logic        w_note_end;
    logic        w_gap_end;
    logic [31:0] w_tick_next;
    logic [15:0] w_ms_next;

`ifdef TONE_SEQ_MUTE_EN
    assign w_mute = bus.mute;
`else
    assign w_mute = 1'b0;
`endif

    // OVER outranks everything and cannot be interrupted; EAT restarts itself
    assign w_over_active = (r_state != S_IDLE) && (r_idx >= 3'd3);
    assign w_start_over  = bus.play_over && !w_over_active;
    assign w_start_eat   = bus.play_eat && !bus.play_over && !w_over_active;
    assign w_start_idx   = w_start_over ? 3'd3 : 3'd0;
    assign w_start_freq  = note_freq(w_start_idx);
    assign w_next_idx    = r_idx + 3'd1;
    assign w_next_freq   = note_freq(w_next_idx);
    assign w_cur_freq    = note_freq(r_idx);
    assign w_cur_dur     = note_dur(r_idx);
    assign w_last        = (r_idx == 3'd2) || (r_idx == 3'd7);

    assign w_tick_wrap = (r_tick == TICK_LAST);
    assign w_note_end  = w_tick_wrap && (r_ms == w_cur_dur - 16'd1);
    assign w_gap_end   = w_tick_wrap && (r_ms == GAP_LAST);
    assign w_tick_next = w_tick_wrap ? 32'd0 : r_tick + 32'd1;
    assign w_ms_next   = w_tick_wrap ? r_ms + 16'd1 : r_ms;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_idx     <= 3'd0;
            r_tick    <= 32'd0;
            r_ms      <= 16'd0;
            r_freq    <= 32'd0;
            r_tone_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start_over || w_start_eat) begin
                r_state   <= S_PLAY;
                r_idx     <= w_start_idx;
                r_tick    <= 32'd0;
                r_ms      <= 16'd0;
                r_busy    <= 1'b1;
                r_freq    <= w_mute ? 32'd0 : w_start_freq;
                r_tone_en <= !w_mute && (w_start_freq != 32'd0);
            end else begin
                case (r_state)
                    S_PLAY: begin
                        if (w_note_end) begin
                            r_tick    <= 32'd0;
                            r_ms      <= 16'd0;
                            r_freq    <= 32'd0;
                            r_tone_en <= 1'b0;
                            if (w_last) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_GAP;
                            end
                        end else begin
                            r_tick    <= w_tick_next;
                            r_ms      <= w_ms_next;
                            // re-evaluated every cycle so unmuting restores the note at once
                            r_freq    <= w_mute ? 32'd0 : w_cur_freq;
                            r_tone_en <= !w_mute && (w_cur_freq != 32'd0);
                        end
                    end
                    S_GAP: begin
                        if (w_gap_end) begin
                            r_state   <= S_PLAY;
                            r_idx     <= w_next_idx;
                            r_tick    <= 32'd0;
                            r_ms      <= 16'd0;
                            r_freq    <= w_mute ? 32'd0 : w_next_freq;
                            r_tone_en <= !w_mute && (w_next_freq != 32'd0);
                        end else begin
                            r_tick <= w_tick_next;
                            r_ms   <= w_ms_next;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.freq      = r_freq;
    assign bus.tone_en   = r_tone_en;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.dbg_state = r_state;

endmodule
